// File: rtl/ntt_poly_unloader.sv
// ntt_poly_unloader: drains the parallel coefficient array produced by the
// ntt block and replays it as a row-major valid/ready stream, one coefficient
// per beat, optionally reduced to the canonical range [0, KYBER_Q).
module ntt_poly_unloader #(
    parameter int COEF_W  = 16,
    parameter int N_ROWS  = 8,
    parameter int N_COLS  = 32,
    parameter int KYBER_Q = 3329,
    parameter int CANON   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic signed [COEF_W-1:0] i_data [0:N_ROWS-1][0:N_COLS-1],
    output logic                     o_in_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [COEF_W-1:0] o_data,
    output logic [7:0]               o_index,
    output logic                     o_last,
    output logic                     o_range_err
);

    localparam int         TOTAL    = N_ROWS * N_COLS;
    localparam int         EXT_W    = COEF_W + 2;
    localparam logic [7:0] LAST_IDX = 8'(TOTAL - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [7:0]                 idx;
    logic signed [COEF_W-1:0]   buffer [0:TOTAL-1];
    logic                       capture;
    logic                       xfer;
    logic signed [COEF_W-1:0]   raw;
    logic                       range_err;

    // Single conditional add/subtract of Q; only fully reduces x in [-Q, 2Q).
    function automatic logic signed [COEF_W-1:0] canon_reduce(input logic signed [COEF_W-1:0] x);
        logic signed [EXT_W-1:0] xe;
        logic signed [EXT_W-1:0] q;
        logic signed [EXT_W-1:0] y;
        xe = {{2{x[COEF_W-1]}}, x};
        q  = EXT_W'(KYBER_Q);
        if (xe[EXT_W-1])
            y = xe + q;
        else if (xe >= q)
            y = xe - q;
        else
            y = xe;
        return y[COEF_W-1:0];
    endfunction

    // True when the single-step reduction above yields a canonical result.
    function automatic logic in_range(input logic signed [COEF_W-1:0] x);
        logic signed [EXT_W-1:0] xe;
        logic signed [EXT_W-1:0] lo;
        logic signed [EXT_W-1:0] hi;
        xe = {{2{x[COEF_W-1]}}, x};
        lo = EXT_W'(-KYBER_Q);
        hi = EXT_W'(2 * KYBER_Q);
        return (xe >= lo) && (xe < hi);
    endfunction

    assign capture = (state == IDLE) && i_valid;
    assign xfer    = (state == STREAM) && i_ready;
    assign raw     = buffer[idx];

    // State register; reset abandons any array in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: capture starts a stream, the transfer of the last beat ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = STREAM;
            STREAM:  if (i_ready && (idx == LAST_IDX)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from registered state, so o_valid never depends on i_ready.
    always_comb begin
        o_in_ready  = (state == IDLE);
        o_valid     = (state == STREAM);
        o_index     = idx;
        o_last      = (state == STREAM) && (idx == LAST_IDX);
        o_range_err = range_err;
        o_data      = '0;
        if (state == STREAM) begin
            if (CANON != 0)
                o_data = canon_reduce(raw);
            else
                o_data = raw;
        end
    end

    // Read pointer: cleared at capture, advanced on each accepted beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            idx <= '0;
        else if (capture)
            idx <= '0;
        else if (xfer)
            idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    end

    // Sticky out-of-range flag, scoped to one captured array.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            range_err <= 1'b0;
        else if (capture)
            range_err <= 1'b0;
        else if (xfer && (CANON != 0) && !in_range(raw))
            range_err <= 1'b1;
    end

    // Coefficient buffer, flattened row-major; written only at capture.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            for (int r = 0; r < N_ROWS; r++) begin
                for (int c = 0; c < N_COLS; c++) begin
                    buffer[r*N_COLS + c] <= i_data[r][c];
                end
            end
        end
    end

endmodule

// File: doc/ntt_poly_unloader.md
Name: ntt_poly_unloader

Overview:
- Drains the parallel 8x32 coefficient array from the ntt block (o_valid / o_data) and re-serialises it as 256 coefficients, one per beat, on a valid/ready stream.
- Optionally reduces each coefficient to canonical form [0, KYBER_Q) on the way out.
- Sits between ntt and the downstream packer/compress stage. It is the output-side counterpart of ntt's serial input loading.

Parameters:
- COEF_W, 16, coefficient width in bits (two's complement, signed).
- N_ROWS, 8, rows of the input array.
- N_COLS, 32, columns per row. N_ROWS*N_COLS = 256 coefficients.
- KYBER_Q, 3329, modulus used for canonical reduction.
- CANON, 1, 1 = emit the canonical value in [0, KYBER_Q); 0 = emit the raw signed value unchanged.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  array-valid from ntt o_valid; sampled only while o_in_ready=1.
- i_data  in  [0:N_ROWS-1][0:N_COLS-1] x COEF_W signed  coefficient array from ntt o_data.
- o_in_ready  out  1  high in IDLE; the block can accept a new array.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_data  out  COEF_W signed  current coefficient.
- o_index  out  8  index of the current coefficient, = row*N_COLS + col.
- o_last  out  1  high with the beat for o_index = 255.
- o_range_err  out  1  sticky flag: an emitted coefficient lay outside [-KYBER_Q, 2*KYBER_Q).

Behaviour:
- Reset (async, i_rst_n=0), all values forced immediately:
  - state = IDLE, o_in_ready=1, o_valid=0, o_data=0, o_index=0, o_last=0, o_range_err=0.
  - Buffer contents are don't-care.
  - Reset mid-stream abandons the array; no further beats until a new i_valid.
- FSM:
  - IDLE: o_in_ready=1. At a clock edge with i_valid=1, register all 256 coefficients into the internal buffer, clear o_range_err, set index=0, go to STREAM.
  - STREAM: o_in_ready=0. i_valid is ignored, with no capture and no error.
  - A beat transfers at an edge where o_valid && i_ready.
  - Transfer with index<255: index increments.
  - Transfer with index=255: return to IDLE. o_valid=0 and o_in_ready=1 from the next cycle.
- Latency: capture edge T gives o_valid=1 with index 0 from T (registered, visible after T). With i_ready held high, 256 consecutive beats follow and IDLE is re-entered one edge after beat 255.
- Order is row-major: index k = row*32 + col, source i_data[k/32][k%32].
- Backpressure: while o_valid && !i_ready, o_data, o_index and o_last hold stable. There is no dependency of o_valid on i_ready.
- o_last = (o_index == 255) && o_valid.
- Reduction (CANON=1), combinational on the buffered value x, sign-extended to COEF_W+2 bits:
  - x<0: y = x + Q.
  - Else if x >= Q: y = x - Q.
  - Else: y = x.
  - Valid for x in [-Q, 2Q). Outside that range the output is y as computed (not fully reduced) and o_range_err is set at the transfer edge of that beat.
  - o_range_err stays set until the next capture or reset.
- CANON=0: o_data = x and the range check is disabled (o_range_err is always 0).
- Buffer: 256 x COEF_W registers, written only at the capture edge. The read mux is selected by the index register.
- Simultaneous events:
  - i_valid high on the same edge as the beat-255 transfer: ignored, because o_in_ready is still 0. The source holds i_valid, and it is accepted on the following edge.
- i_ready while o_valid=0 has no effect.

Test Plan:
- Basic drain:
  - Stimulus: capture i_data[r][c] = (32r+c) mod 3329 with i_ready=1.
  - Required: 256 beats on consecutive cycles, o_data = o_index = 0..255, o_last only on beat 255, o_in_ready back to 1 one cycle later.
- Canonical reduction:
  - Stimulus: entries -1, -3329, 3329, 6657, 5000, 0 at indices 0..5.
  - Required: o_data = 3328, 0, 0, 3328, 1671, 0.
  - Then an entry of -3330 → o_data=-1 and o_range_err=1, which persists to the end and clears on the next capture.
- Backpressure:
  - Stimulus: toggle i_ready with pattern 1,0,0,1 repeating.
  - Required: no beats lost or duplicated, outputs stable during stalls, 256 transfers total, o_index strictly sequential.
- Ignore during stream:
  - Stimulus: pulse i_valid with a different array at index 100.
  - Required: the stream continues with the original data, and the new array is not captured.
- Reset mid-stream:
  - Stimulus: assert i_rst_n=0 asynchronously (not clock-aligned) at index 37.
  - Required: o_valid=0 and o_index=0 immediately. After release plus a new capture, the stream restarts at index 0 with the new data.
- CANON=0 build:
  - Stimulus: -5 and 4000.
  - Required: o_data is emitted raw as -5 and 4000, and o_range_err stays 0.
